// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: byte-lane alignment, doubleword split into two bus beats, load extension.
// Compile-time option MISALIGN_TRAP_EN adds misalign_trap and answers misaligned accesses without bus traffic.
module mem_access_unit #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_we,
  input  logic [2:0]        memControl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              resp_valid,
  output logic [63:0]       rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [63:0]       dmem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_trap
`endif
);

  // memControl size/sign codes shared with the ID-stage decoder
  localparam logic [2:0] MEM_NONE  = 3'd0;
  localparam logic [2:0] MEM_BYTE  = 3'd1;
  localparam logic [2:0] MEM_HALF  = 3'd2;
  localparam logic [2:0] MEM_WORD  = 3'd3;
  localparam logic [2:0] MEM_DWORD = 3'd4;
  localparam logic [2:0] MEM_BYTEU = 3'd5;
  localparam logic [2:0] MEM_HALFU = 3'd6;
  localparam logic [2:0] MEM_WORDU = 3'd7;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  state_t      state_reg;
  logic        gap_reg;
  logic        split_reg;
  logic        we_reg;
  logic [2:0]  off_reg;
  logic [2:0]  mc_reg;
  logic [7:0]  strb_hi_reg;
  logic [63:0] wdata_hi_reg;
  logic [63:0] lo_reg;
  logic [63:0] hi_reg;

  logic [1:0]   in_sz;
  logic [3:0]   in_bytes;
  logic [7:0]   in_lanes;
  logic [2:0]   in_off;
  logic [15:0]  in_mask;
  logic         in_split;
  logic [127:0] in_wide;
  logic         accept;
  logic         take_trap;
  logic [63:0]  aligned;
  logic [63:0]  load_result;

  always_comb begin
    in_sz = 2'd0;
    case (memControl)
      MEM_HALF, MEM_HALFU: in_sz = 2'd1;
      MEM_WORD, MEM_WORDU: in_sz = 2'd2;
      MEM_DWORD:           in_sz = 2'd3;
      default:             in_sz = 2'd0;
    endcase
  end

  assign in_bytes = 4'd1 << in_sz;
  assign in_lanes = 8'((9'd1 << in_bytes) - 9'd1);
  assign in_off   = addr[2:0];
  assign in_mask  = {8'd0, in_lanes} << in_off;
  assign in_split = ({1'b0, in_off} + in_bytes) > 4'd8;
  // Upper half of the shifted store data becomes the second beat's payload.
  assign in_wide  = {64'd0, wdata} << {in_off, 3'b000};
  assign accept   = (state_reg == IDLE) && req_valid && (memControl != MEM_NONE);

`ifdef MISALIGN_TRAP_EN
  logic [2:0] align_mask;

  always_comb begin
    case (in_sz)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign take_trap = |(in_off & align_mask);

  // The trapped access goes straight to RESP, so the flag lines up with resp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= accept && take_trap;
    end
  end
`else
  assign take_trap = 1'b0;
`endif

  always_comb begin
    aligned = 64'({hi_reg, lo_reg} >> {off_reg, 3'b000});
    case (mc_reg)
      MEM_BYTE:  load_result = {{56{aligned[7]}},  aligned[7:0]};
      MEM_HALF:  load_result = {{48{aligned[15]}}, aligned[15:0]};
      MEM_WORD:  load_result = {{32{aligned[31]}}, aligned[31:0]};
      MEM_BYTEU: load_result = {56'd0, aligned[7:0]};
      MEM_HALFU: load_result = {48'd0, aligned[15:0]};
      MEM_WORDU: load_result = {32'd0, aligned[31:0]};
      default:   load_result = aligned;
    endcase
  end

  // After each ack there is one idle bus cycle (gap_reg) before the next beat or the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      rdata        <= 64'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 64'd0;
      dmem_wstrb   <= 8'd0;
      gap_reg      <= 1'b0;
      split_reg    <= 1'b0;
      we_reg       <= 1'b0;
      off_reg      <= 3'd0;
      mc_reg       <= MEM_NONE;
      strb_hi_reg  <= 8'd0;
      wdata_hi_reg <= 64'd0;
      lo_reg       <= 64'd0;
      hi_reg       <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_ready    <= 1'b0;
            we_reg       <= mem_we;
            off_reg      <= in_off;
            mc_reg       <= memControl;
            split_reg    <= in_split;
            strb_hi_reg  <= mem_we ? in_mask[15:8] : 8'd0;
            wdata_hi_reg <= mem_we ? in_wide[127:64] : 64'd0;
            lo_reg       <= 64'd0;
            hi_reg       <= 64'd0;
            gap_reg      <= 1'b0;
            if (take_trap) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              rdata      <= 64'd0;
            end else begin
              state_reg  <= BEAT1;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_we;
              dmem_addr  <= {addr[ADDR_W-1:3], 3'b000};
              dmem_wstrb <= mem_we ? in_mask[7:0] : 8'd0;
              dmem_wdata <= mem_we ? in_wide[63:0] : 64'd0;
            end
          end
        end

        BEAT1: begin
          if (gap_reg) begin
            gap_reg <= 1'b0;
            if (split_reg) begin
              state_reg  <= BEAT2;
              dmem_req   <= 1'b1;
              dmem_we    <= we_reg;
              dmem_addr  <= dmem_addr + ADDR_W'(8);
              dmem_wstrb <= strb_hi_reg;
              dmem_wdata <= wdata_hi_reg;
            end else begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              rdata      <= we_reg ? 64'd0 : load_result;
            end
          end else if (dmem_ack) begin
            lo_reg     <= dmem_rdata;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 8'd0;
            gap_reg    <= 1'b1;
          end
        end

        BEAT2: begin
          if (gap_reg) begin
            gap_reg    <= 1'b0;
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            rdata      <= we_reg ? 64'd0 : load_result;
          end else if (dmem_ack) begin
            hi_reg     <= dmem_rdata;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 8'd0;
            gap_reg    <= 1'b1;
          end
        end

        RESP: begin
          state_reg  <= IDLE;
          resp_valid <= 1'b0;
          rdata      <= 64'd0;
          req_ready  <= 1'b1;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
